// File: rtl/sdram_pkg.sv
// sdram_pkg: SDRAM command word layout, 74595 lane bit maps and command encodings
package sdram_pkg;

   typedef struct packed {
      logic        cke;
      logic        csb;
      logic        rasb;
      logic        casb;
      logic        web;
      logic [1:0]  dqm;
      logic [1:0]  ba;
      logic [12:0] addr;
   } sdram_cmd_t;

   // {csb, rasb, casb, web}
   localparam logic [3:0] CMD_INHIBIT   = 4'b1111;
   localparam logic [3:0] CMD_NOP       = 4'b0111;
   localparam logic [3:0] CMD_ACTIVATE  = 4'b0011;
   localparam logic [3:0] CMD_READ      = 4'b0101;
   localparam logic [3:0] CMD_WRITE     = 4'b0100;
   localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
   localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;

   localparam sdram_cmd_t INHIBIT_WORD = 22'h3E0000;

   // Bit positions in the command word, written Q_H..Q_A per lane; 22 selects a constant 0
   localparam logic [2:0][7:0][4:0] LANE_MAP = {
      {5'd22, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd16, 5'd15},
      {5'd14, 5'd10, 5'd0,  5'd1,  5'd2,  5'd3,  5'd22, 5'd13},
      {5'd5,  5'd6,  5'd7,  5'd8,  5'd9,  5'd11, 5'd12, 5'd4}
   };

   function automatic sdram_cmd_t mk_cmd(input logic [3:0] code, input logic [1:0] ba,
                                         input logic [12:0] addr);
      mk_cmd = {1'b1, code, 2'b00, ba, addr};
   endfunction

   // Parallel byte for one 74595, bit 7 = Q_H (shifted first), bit 0 = Q_A
   function automatic logic [7:0] lane_bits(input sdram_cmd_t c, input int l);
      logic [22:0] x;
      x = {1'b0, c};
      for (int i = 0; i < 8; i++) lane_bits[i] = x[LANE_MAP[l][i]];
   endfunction

endpackage

// File: rtl/sr_piso8.sv
// sr_piso8: 8-bit parallel-load shift register, Q_H (MSB) first out
module sr_piso8 (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       shift,
   input  logic [7:0] d,
   output logic       q_h
);
   logic [7:0] sr;
   assign q_h = sr[7];
   // load has priority; shifting moves the next lower bit up to Q_H
   always_ff @(posedge clk) begin
      if (rst) sr <= '0;
      else if (load) sr <= d;
      else if (shift) sr <= {sr[6:0], 1'b0};
   end
endmodule

// File: rtl/sdram_cmd_shifter.sv
// sdram_cmd_shifter: serialises an SDRAM command word onto three 74595 lanes with shared srclk/rclk
module sdram_cmd_shifter
   import sdram_pkg::*;
#(
   parameter int HALF_PERIOD = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  sdram_cmd_t cmd,
   output logic       srclk,
   output logic       rclk,
   output logic       ser1,
   output logic       ser2,
   output logic       ser3,
   output logic       busy
);
   localparam logic [2:0] INIT     = 3'd0;
   localparam logic [2:0] IDLE     = 3'd1;
   localparam logic [2:0] BIT_LO   = 3'd2;
   localparam logic [2:0] BIT_HI   = 3'd3;
   localparam logic [2:0] LATCH_HI = 3'd4;
   localparam logic [2:0] LATCH_LO = 3'd5;
   localparam int PW = $clog2(HALF_PERIOD + 1);
   localparam logic [PW-1:0] PH_LAST = PW'(HALF_PERIOD - 1);

   logic [2:0]    state;
   logic [PW-1:0] phase;
   logic [2:0]    bit_cnt;
   logic          start, ph_end, shift_en;
   logic [2:0]    q;
   sdram_cmd_t    word;

   // INIT launches the inhibit frame by itself; IDLE launches on a handshake
   assign start     = state == INIT || (state == IDLE && cmd_valid);
   assign word      = state == INIT ? INHIBIT_WORD : cmd;
   assign ph_end    = phase == PH_LAST;
   assign shift_en  = state == BIT_HI && ph_end;
   assign cmd_ready = state == IDLE;
   assign busy      = !cmd_ready;
   assign srclk     = state == BIT_HI;
   assign rclk      = state == LATCH_HI;
   assign {ser3, ser2, ser1} = (state == BIT_LO || state == BIT_HI) ? q : 3'b000;

   for (genvar l = 0; l < 3; l++) begin : g_lane
      sr_piso8 u_sr (
         .clk   (clk),
         .rst   (rst),
         .load  (start),
         .shift (shift_en),
         .d     (lane_bits(word, l)),
         .q_h   (q[l])
      );
   end

   // frame sequencer: every phase lasts HALF_PERIOD cycles, eight bit pairs then the latch pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= INIT;
         phase   <= '0;
         bit_cnt <= '0;
      end else if (start) begin
         state <= BIT_LO;
         phase <= '0;
      end else if (state != IDLE) begin
         phase <= ph_end ? '0 : phase + PW'(1);
         if (ph_end) begin
            if (state == BIT_HI) bit_cnt <= bit_cnt + 3'd1;
            state <= state == BIT_LO ? BIT_HI :
                     state == BIT_HI ? (bit_cnt == 3'd7 ? LATCH_HI : BIT_LO) :
                     state == LATCH_HI ? LATCH_LO : IDLE;
         end
      end
   end
endmodule

// File: tb/tb_sdram_cmd_shifter.sv
// tb_sdram_cmd_shifter: two shifters (HALF_PERIOD 1 and 3) driving behavioural 74595s and an SDRAM pin model
module tb_sdram_cmd_shifter;
   import sdram_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0] rst_w = 2'b11;
   logic [1:0] valid_w = 2'b00;
   sdram_cmd_t cmd_w [2];
   wire [1:0] ready_w, busy_w, srclk_w, rclk_w;
   wire [2:0] ser_a, ser_b;

   sdram_cmd_shifter #(.HALF_PERIOD(1)) dut1 (
      .clk(clk), .rst(rst_w[0]), .cmd_valid(valid_w[0]), .cmd_ready(ready_w[0]), .cmd(cmd_w[0]),
      .srclk(srclk_w[0]), .rclk(rclk_w[0]), .ser1(ser_a[0]), .ser2(ser_a[1]), .ser3(ser_a[2]),
      .busy(busy_w[0]));

   sdram_cmd_shifter #(.HALF_PERIOD(3)) dut3 (
      .clk(clk), .rst(rst_w[1]), .cmd_valid(valid_w[1]), .cmd_ready(ready_w[1]), .cmd(cmd_w[1]),
      .srclk(srclk_w[1]), .rclk(rclk_w[1]), .ser1(ser_b[0]), .ser2(ser_b[1]), .ser3(ser_b[2]),
      .busy(busy_w[1]));

   // behavioural 74595s: sr = shift stage {Q_H..Q_A}, lat = storage stage
   logic [7:0] sr [2][3];
   logic [7:0] lat [2][3];
   sdram_cmd_t pins [2];
   logic [1:0] psrclk = 2'b00, prclk = 2'b00;
   logic [2:0] pser [2];
   int rclk_cnt [2], viol [2], burst_len [2];
   logic [2:0] cas_lat [2];
   int checks = 0, errors = 0;

   function automatic int hp(input int d);
      return d == 0 ? 1 : 3;
   endfunction

   // SDRAM pin view of the three latched 74595 outputs (index 0 = Q_A)
   function automatic sdram_cmd_t decode(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      sdram_cmd_t p;
      p.cke  = c[2];
      p.csb  = c[3];
      p.rasb = c[4];
      p.casb = c[5];
      p.web  = c[6];
      p.dqm  = {c[1], c[0]};
      p.ba   = {b[7], b[0]};
      p.addr = {a[1], a[2], b[6], a[3], a[4], a[5], a[6], a[7], a[0], b[2], b[3], b[4], b[5]};
      return p;
   endfunction

   function automatic sdram_cmd_t rand_cmd();
      logic [21:0] r;
      r = 22'($urandom);
      return r;
   endfunction

   always @(negedge clk) begin
      logic [2:0] s;
      for (int d = 0; d < 2; d++) begin
         s = d == 0 ? ser_a : ser_b;
         if (srclk_w[d] && s !== pser[d]) viol[d]++;
         if (srclk_w[d] && !psrclk[d])
            for (int l = 0; l < 3; l++) sr[d][l] = {sr[d][l][6:0], s[l]};
         if (rclk_w[d] && !prclk[d]) begin
            for (int l = 0; l < 3; l++) lat[d][l] = sr[d][l];
            pins[d] = decode(lat[d][0], lat[d][1], lat[d][2]);
            if (pins[d].cke && !pins[d].csb && !pins[d].rasb && !pins[d].casb && !pins[d].web) begin
               cas_lat[d]   = pins[d].addr[6:4];
               burst_len[d] = 1 << pins[d].addr[2:0];
            end
            rclk_cnt[d]++;
         end
         psrclk[d] = srclk_w[d];
         prclk[d]  = rclk_w[d];
         pser[d]   = s;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready(input int d, output int n);
      n = 0;
      while (!ready_w[d] && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   // release reset: the first edge with rst low starts the inhibit frame
   task automatic boot(input int d);
      int n;
      int r0;
      r0 = rclk_cnt[d];
      rst_w[d] = 1'b0;
      wait_ready(d, n);
      chk($sformatf("boot%0d_len", hp(d)), n, 18 * hp(d) + 1);
      chk($sformatf("boot%0d_rclk", hp(d)), rclk_cnt[d] - r0, 1);
      chk($sformatf("boot%0d_pins", hp(d)), pins[d], INHIBIT_WORD);
   endtask

   task automatic send(input int d, input sdram_cmd_t c, input string tag);
      int n;
      int r0;
      r0 = rclk_cnt[d];
      wait_ready(d, n);
      cmd_w[d] = c;
      valid_w[d] = 1'b1;
      @(posedge clk);
      #1;
      valid_w[d] = 1'b0;
      cmd_w[d] = rand_cmd();
      wait_ready(d, n);
      chk({tag, "_len"}, n, 18 * hp(d));
      chk({tag, "_rclk"}, rclk_cnt[d] - r0, 1);
      chk({tag, "_pins"}, pins[d], c);
   endtask

   initial begin
      int n;
      int r0;
      sdram_cmd_t prev, a, b;
      for (int d = 0; d < 2; d++) begin
         cmd_w[d] = '0;
         pins[d] = '0;
         pser[d] = '0;
         rclk_cnt[d] = 0;
         viol[d] = 0;
         burst_len[d] = 0;
         cas_lat[d] = '0;
         for (int l = 0; l < 3; l++) begin
            sr[d][l] = '0;
            lat[d][l] = '0;
         end
      end
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", ready_w, 2'b00);
      chk("rst_busy", busy_w, 2'b11);
      chk("rst_srclk", srclk_w, 2'b00);
      chk("rst_rclk", rclk_w, 2'b00);
      chk("rst_ser", {ser_b, ser_a}, 6'b0);
      boot(0);
      boot(1);

      send(0, mk_cmd(CMD_ACTIVATE, 2'd0, 13'd0), "act");
      chk("act_ser3", sr[0][2], 8'b01100100);
      chk("act_ser1", sr[0][0], 8'b0);
      chk("act_ser2", sr[0][1], 8'b0);
      send(0, mk_cmd(CMD_PRECHARGE, 2'd0, 13'h400), "pre");
      chk("pre_ser2", sr[0][1], 8'b01000000);
      chk("pre_a10", pins[0].addr[10], 1'b1);
      chk("pre_web", pins[0].web, 1'b0);
      send(0, mk_cmd(CMD_LOAD_MODE, 2'd0, 13'h220), "lmr");
      chk("lmr_ser1", sr[0][0], 8'b10001000);
      chk("lmr_cas", cas_lat[0], 3'd2);
      chk("lmr_bl", burst_len[0], 1);

      for (int i = 0; i < 6; i++) send(0, rand_cmd(), $sformatf("rnd1_%0d", i));
      send(1, mk_cmd(CMD_ACTIVATE, 2'd0, 13'd0), "act3");
      chk("act3_ser3", sr[1][2], 8'b01100100);
      for (int i = 0; i < 3; i++) send(1, rand_cmd(), $sformatf("rnd3_%0d", i));

      // back-to-back with cmd_valid held: second word taken on the first ready cycle
      a = rand_cmd();
      b = rand_cmd();
      r0 = rclk_cnt[0];
      wait_ready(0, n);
      cmd_w[0] = a;
      valid_w[0] = 1'b1;
      @(posedge clk);
      #1;
      cmd_w[0] = b;
      wait_ready(0, n);
      chk("b2b_busy", n, 18);
      chk("b2b_first", pins[0], a);
      @(posedge clk);
      #1;
      chk("b2b_accept", ready_w[0], 1'b0);
      valid_w[0] = 1'b0;
      cmd_w[0] = rand_cmd();
      wait_ready(0, n);
      chk("b2b_busy2", n, 18);
      chk("b2b_second", pins[0], b);
      chk("b2b_rclk", rclk_cnt[0] - r0, 2);

      // reset in the middle of a WRITE: nothing latched, then INIT replays inhibit
      prev = pins[0];
      r0 = rclk_cnt[0];
      wait_ready(0, n);
      cmd_w[0] = mk_cmd(CMD_WRITE, 2'd1, 13'h0F0);
      valid_w[0] = 1'b1;
      @(posedge clk);
      #1;
      valid_w[0] = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      rst_w[0] = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_ready", ready_w[0], 1'b0);
      chk("mid_rst_busy", busy_w[0], 1'b1);
      chk("mid_rst_srclk", srclk_w[0], 1'b0);
      chk("mid_rst_ser", ser_a, 3'b000);
      repeat (2) @(posedge clk);
      #1;
      chk("mid_rst_rclk", rclk_cnt[0] - r0, 0);
      chk("mid_rst_pins", pins[0], prev);
      boot(0);
      send(0, mk_cmd(CMD_READ, 2'd2, 13'h155), "post_rst");

      chk("ser_stable1", viol[0], 0);
      chk("ser_stable3", viol[1], 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
